// File: rtl/regf_pkg.sv
// Shared widths, requester ids and payload type for the register-file writeback path.
package regf_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // True when two or more of up to eight requesters are valid.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from rr_ptr, pointer moves past each winner.
module rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] rr_ptr;
  int unsigned      scan;

  // First valid index at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    scan    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan = 32'(rr_ptr) + k;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (en && !gnt_vld && req[IDX_W'(scan)]) begin
        gnt[IDX_W'(scan)] = 1'b1;
        gnt_idx           = IDX_W'(scan);
        gnt_vld           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      if (32'(gnt_idx) == N_REQ - 1) rr_ptr <= '0;
      else                           rr_ptr <= gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/regf_wb_arbiter.sv
// Arbitrates writeback sources onto the single register-file write port, with a
// registered output stage, operand forwarding flags and a saturating conflict counter.
module regf_wb_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = regf_pkg::DATA_W,
  parameter int unsigned ADDR_W = regf_pkg::ADDR_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    wb_en,
  output logic [ADDR_W-1:0]       wb_addr,
  output logic [DATA_W-1:0]       wb_data,
  input  logic [ADDR_W-1:0]       rd_addr_a,
  input  logic [ADDR_W-1:0]       rd_addr_b,
  output logic                    fwd_a_hit,
  output logic                    fwd_b_hit,
  output logic [CNT_W-1:0]        conflict_cnt
);

  import regf_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              arb_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Reset gates grants so req_ready is low throughout reset.
  assign arb_en    = rst && !hold;
  assign req_ready = gnt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(gnt_idx) == i) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to x0 are consumed but never raise the write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (gnt_vld) begin
      wb_en   <= sel_addr != '0;
      wb_addr <= sel_addr;
      wb_data <= sel_data;
    end else begin
      wb_en   <= 1'b0;
    end
  end

  assign fwd_a_hit = wb_en && (wb_addr == rd_addr_a) && (rd_addr_a != '0);
  assign fwd_b_hit = wb_en && (wb_addr == rd_addr_b) && (rd_addr_b != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (!hold && multi_hot(8'(req_valid)) && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule
